// File: rtl/fxd_pkg.sv
// Shared types and width helpers for the fixed-point Horner evaluator.
package fxd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READY = 2'b01,
    CALC  = 2'b10,
    DONE  = 2'b11
  } horner_state_typ;

  // Full signed product width of two fxd_n-bit words.
  function automatic int fxd_prod_width(input int fxd_n);
    return 2 * fxd_n;
  endfunction

  // Counter only ever holds 0..num_coef-2, so one bit suffices for short polynomials.
  function automatic int fxd_cnt_width(input int num_coef);
    return (num_coef > 2) ? $clog2(num_coef - 1) : 1;
  endfunction

endpackage

// File: rtl/fxd_mul_shift.sv
// Combinational fixed-point multiply: full signed product, floor shift by FRAC_N, wrap to FXD_N bits.
module fxd_mul_shift
  import fxd_pkg::*;
#(
  parameter int FXD_N  = 32,
  parameter int FRAC_N = 30
) (
  input  logic signed [FXD_N-1:0] a,
  input  logic signed [FXD_N-1:0] b,
  output logic signed [FXD_N-1:0] y
);

  localparam int PW = fxd_prod_width(FXD_N);

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] prod;
  logic                 unused_prod_bits;

  assign a_ext = PW'(a);
  assign b_ext = PW'(b);
  assign prod  = a_ext * b_ext;

  // Selecting bits above FRAC_N of the signed product is an arithmetic shift (floor) followed by a wrap.
  assign y = prod[FRAC_N +: FXD_N];

  assign unused_prod_bits = ^{prod[PW-1:FRAC_N+FXD_N], prod[FRAC_N-1:0]};

endmodule

// File: rtl/horner_eval.sv
// Iterative Horner polynomial evaluator with avail/get handshakes on both sides.
module horner_eval
  import fxd_pkg::*;
#(
  parameter int                        FXD_N    = 32,
  parameter int                        FRAC_N   = 30,
  parameter int                        NUM_COEF = 4,
  parameter logic [NUM_COEF*FXD_N-1:0] COEF     = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pre_avail,
  output logic             pre_get,
  input  logic [FXD_N-1:0] pre_data,
  output logic             post_avail,
  input  logic             post_get,
  output logic [FXD_N-1:0] post_data
);

  localparam int                CNT_W      = fxd_cnt_width(NUM_COEF);
  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'((NUM_COEF > 1) ? NUM_COEF - 2 : 0);
  localparam logic [FXD_N-1:0]  C_TOP      = COEF[(NUM_COEF-1)*FXD_N +: FXD_N];
  localparam horner_state_typ   LOAD_NEXT  = (NUM_COEF == 1) ? DONE : CALC;

  horner_state_typ  state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [FXD_N-1:0] x_reg;
  logic [FXD_N-1:0] acc;
  logic [FXD_N-1:0] coef_sel;
  logic [FXD_N-1:0] mul_out;
  logic             load;
  logic             step;

  assign coef_sel  = COEF[int'(cnt)*FXD_N +: FXD_N];
  assign post_data = acc;

  fxd_mul_shift #(
    .FXD_N (FXD_N),
    .FRAC_N(FRAC_N)
  ) u_mul (
    .a(acc),
    .b(x_reg),
    .y(mul_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Handshake outputs are decoded from state so reset clears them immediately.
  always_comb begin
    next_state = state;
    pre_get    = 1'b0;
    post_avail = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    unique case (state)
      IDLE: begin
        next_state = READY;
      end
      READY: begin
        pre_get = 1'b1;
        if (pre_avail) begin
          load       = 1'b1;
          next_state = LOAD_NEXT;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt == '0) next_state = DONE;
      end
      DONE: begin
        post_avail = 1'b1;
        pre_get    = post_get;
        if (post_get) begin
          if (pre_avail) begin
            load       = 1'b1;
            next_state = LOAD_NEXT;
          end else begin
            next_state = READY;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_RELOAD;
    end else if (step) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Datapath registers carry no reset; the FSM never presents them before a load.
  always_ff @(posedge clk) begin
    if (load) begin
      x_reg <= pre_data;
      acc   <= C_TOP;
    end else if (step) begin
      acc <= mul_out + coef_sel;
    end
  end

endmodule

// File: tb/tb_horner_eval.sv
// Self-checking bench for horner_eval: Q16.16, three coefficients, directed and random vectors.
module tb_horner_eval;

  localparam int          FXD_N    = 32;
  localparam int          FRAC_N   = 16;
  localparam int          NUM_COEF = 3;
  localparam logic [31:0] C0       = 32'h0001_0000;
  localparam logic [31:0] C1       = 32'h0002_0000;
  localparam logic [31:0] C2       = 32'h0000_8000;
  localparam int          BUDGET   = 40;

  logic        clk;
  logic        rst_n;
  logic        pre_avail;
  logic        pre_get;
  logic [31:0] pre_data;
  logic        post_avail;
  logic        post_get;
  logic [31:0] post_data;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [31:0] x;
    logic [31:0] expected;
  } vec_t;

  vec_t vecs [5];

  horner_eval #(
    .FXD_N   (FXD_N),
    .FRAC_N  (FRAC_N),
    .NUM_COEF(NUM_COEF),
    .COEF    ({C2, C1, C0})
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pre_avail (pre_avail),
    .pre_get   (pre_get),
    .pre_data  (pre_data),
    .post_avail(post_avail),
    .post_get  (post_get),
    .post_data (post_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: real-valued Horner in integer-scaled form, product floored by 2^16, sums wrapping at 32 bits.
  function automatic logic [31:0] model(input logic [31:0] x);
    logic [31:0] c [3];
    logic [31:0] acc32;
    longint      prod;
    c[0] = C0; c[1] = C1; c[2] = C2;
    acc32 = c[2];
    for (int k = 1; k >= 0; k--) begin
      prod  = longint'($signed(acc32)) * longint'($signed(x));
      prod  = prod >>> FRAC_N;
      acc32 = prod[31:0] + c[k];
    end
    return acc32;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!pre_get && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (!pre_get) check_output("wait_pre_get_timeout", 32'(pre_get), 32'd1);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!post_avail && lat < BUDGET) begin
      @(negedge clk);
      lat++;
    end
    if (!post_avail) check_output("wait_post_avail_timeout", 32'(post_avail), 32'd1);
  endtask

  // Capture x on one edge, check latency and result, then drain the result.
  task automatic apply_stimulus(input logic [31:0] x, input logic [31:0] expected, input string name);
    int lat;
    wait_ready();
    pre_avail = 1'b1;
    pre_data  = x;
    @(negedge clk);
    pre_avail = 1'b0;
    wait_result(lat);
    check_output({name, "_latency"}, 32'(lat), 32'd2);
    check_output({name, "_data"}, post_data, expected);
    post_get = 1'b1;
    @(negedge clk);
    post_get = 1'b0;
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] xs [4];
    int          lat;
    int          idx_in;
    int          idx_out;
    int          last_cyc;
    logic [31:0] rx;

    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    pre_avail = 1'b0;
    post_get  = 1'b0;
    pre_data  = '0;

    vecs[0] = '{32'h0002_0000, 32'h0007_0000};
    vecs[1] = '{32'hFFFF_0000, 32'hFFFF_8000};
    vecs[2] = '{32'h0000_0001, 32'h0001_0002};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000_FFFE};
    vecs[4] = '{32'h7FFF_0000, 32'h7FFF_8000};

    repeat (2) @(negedge clk);
    check_output("reset_pre_get", 32'(pre_get), 32'd0);
    check_output("reset_post_avail", 32'(post_avail), 32'd0);
    rst_n = 1'b1;
    #1 check_output("idle_pre_get", 32'(pre_get), 32'd0);
    @(negedge clk);
    check_output("ready_pre_get", 32'(pre_get), 32'd1);

    for (int i = 0; i < 5; i++) begin
      apply_stimulus(vecs[i].x, vecs[i].expected, $sformatf("vec%0d", i));
    end

    // Stalled sink: result must hold, then a new word enters on the releasing edge.
    wait_ready();
    pre_avail = 1'b1;
    pre_data  = 32'h0002_0000;
    @(negedge clk);
    pre_avail = 1'b0;
    wait_result(lat);
    held = post_data;
    check_output("hold_first_data", held, 32'h0007_0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("hold_post_avail", 32'(post_avail), 32'd1);
      check_output("hold_pre_get", 32'(pre_get), 32'd0);
      check_output("hold_post_data", post_data, held);
    end
    post_get  = 1'b1;
    pre_avail = 1'b1;
    pre_data  = 32'hFFFF_0000;
    #1 check_output("release_pre_get", 32'(pre_get), 32'd1);
    @(negedge clk);
    post_get  = 1'b0;
    pre_avail = 1'b0;
    check_output("reload_post_avail", 32'(post_avail), 32'd0);
    check_output("reload_pre_get", 32'(pre_get), 32'd0);
    wait_result(lat);
    check_output("reload_latency", 32'(lat), 32'd2);
    check_output("reload_data", post_data, 32'hFFFF_8000);
    post_get = 1'b1;
    @(negedge clk);
    post_get = 1'b0;

    // Streaming with both sides always ready.
    xs[0] = 32'h0002_0000;
    xs[1] = $urandom;
    xs[2] = 32'hFFFF_0000;
    xs[3] = $urandom;
    idx_in   = 0;
    idx_out  = 0;
    last_cyc = 0;
    post_get = 1'b1;
    for (int cyc = 0; cyc < 60 && idx_out < 4; cyc++) begin
      pre_avail = (idx_in < 4);
      pre_data  = (idx_in < 4) ? xs[idx_in] : 32'h0;
      #1;
      if (post_avail) begin
        check_output($sformatf("stream_data%0d", idx_out), post_data, model(xs[idx_out]));
        if (idx_out > 0) check_output("stream_interval", 32'(cyc - last_cyc), 32'd3);
        last_cyc = cyc;
        idx_out++;
      end
      if (pre_get && pre_avail) idx_in++;
      @(negedge clk);
    end
    check_output("stream_count", 32'(idx_out), 32'd4);
    post_get  = 1'b0;
    pre_avail = 1'b0;

    // Asynchronous reset during CALC.
    wait_ready();
    pre_avail = 1'b1;
    pre_data  = 32'h0003_0000;
    @(negedge clk);
    pre_avail = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_output("rst_calc_pre_get", 32'(pre_get), 32'd0);
    check_output("rst_calc_post_avail", 32'(post_avail), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_output("rst_idle_pre_get", 32'(pre_get), 32'd0);
    @(negedge clk);
    check_output("rst_ready_pre_get", 32'(pre_get), 32'd1);
    check_output("rst_ready_post_avail", 32'(post_avail), 32'd0);
    apply_stimulus(32'h0002_0000, 32'h0007_0000, "after_reset");

    // Asynchronous reset in DONE with the sink asserting get: no transfer, result discarded.
    wait_ready();
    pre_avail = 1'b1;
    pre_data  = 32'h0002_0000;
    @(negedge clk);
    pre_avail = 1'b0;
    wait_result(lat);
    post_get = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_output("rst_done_post_avail", 32'(post_avail), 32'd0);
    check_output("rst_done_pre_get", 32'(pre_get), 32'd0);
    @(negedge clk);
    post_get = 1'b0;
    rst_n    = 1'b1;
    repeat (2) @(negedge clk);
    check_output("rst_done_discarded", 32'(post_avail), 32'd0);

    for (int i = 0; i < 16; i++) begin
      rx = $urandom;
      apply_stimulus(rx, model(rx), $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
